vector_decimator: RTL and testbench
===================================

Name: vector_decimator

Overview:
- Streaming inverse of the lane-duplication stage in the vector ALU datapath.
- Takes full V-lane vectors and halves each one pairwise: lanes 2k and 2k+1 reduce to one lane k.
- Two consecutive input beats are packed into one full V-lane output vector: beat 0 fills the lower half, beat 1 fills the upper half.
- Sits between the Execute ALU result path and the writeback staging register. Valid/ready handshakes on both sides.

Parameters:
- N, 8, lane width in bits.
- V, 16, lanes per vector; must be even and >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  an input vector is presented on A.
- in_ready  output  1  block accepts A this cycle.
- A  input  [V-1:0][N-1:0]  input vector.
- mode  input  1  reduction select, sampled with each accepted beat: 0 = keep even lane, 1 = rounded average.
- flush  input  1  close a half-filled output vector.
- out_valid  output  1  Result holds a complete or flushed vector.
- out_ready  input  1  consumer accepts Result.
- Result  output  [V-1:0][N-1:0]  packed decimated vector.
- out_partial  output  1  Result came from a flush; its upper half is zero.

Behaviour:
- Reset (async assert, sync release):
  - state=EMPTY, Result=0, out_valid=0, out_partial=0.
  - in_ready follows its state rule, so it is 1 in EMPTY.
- States:
  - EMPTY: no beat held.
  - HALF: lower half written.
  - FULL: output vector presented.
- Reduction per lane k in 0..V/2-1:
  - mode=0: r[k]=A[2k].
  - mode=1: r[k]=(A[2k]+A[2k+1]+1)>>1. Unsigned, computed in N+1 bits, result truncated to N bits, never overflows.
- in_ready = (state!=FULL) || out_ready. Combinational; it does not depend on in_valid.
- Accept = in_valid && in_ready. Output handshake = out_valid && out_ready.
- EMPTY, accept: Result[V/2-1:0]=r, go to HALF.
- HALF, accept: Result[V-1:V/2]=r, out_valid=1, out_partial=0, go to FULL. Latency is 1 cycle from the second accepted beat to out_valid.
- HALF, flush && !accept: Result[V-1:V/2]=0, out_valid=1, out_partial=1, go to FULL.
- HALF, flush && accept: the beat wins and flush is ignored. Output is complete and out_partial=0.
- FULL:
  - Result, out_valid and out_partial are held stable until the output handshake.
  - Handshake with no accept: out_valid=0, go to EMPTY.
  - Handshake with accept in the same cycle: new beat goes to the lower half, out_valid=0, go to HALF. No bubble.
- flush in EMPTY or FULL: no effect.
- Upper-half lanes of Result while in HALF keep their previous values and are don't-care (out_valid=0). The bench must not check them.
- Reset asserted mid-operation discards any held half vector and any pending output.
- No combinational path from in_valid to out_valid. The only comb path is out_ready -> in_ready.

Optional Feature:
- Macro DECIMATE_AVG_EN.
- Defined: mode is honoured as above.
- Undefined:
  - The averaging adders are not built and the mode port is ignored; every beat uses even-lane selection (mode=0 behaviour).
  - Port list is unchanged.

Test Plan:
- Even pick, N=8, V=16, mode=0:
  - Stimulus: beat0 A[i]=i, beat1 A[i]=16+i, out_ready=1.
  - Response: Result = {30,28,...,18,16,14,...,2,0} (lane 0=0, lane 15=30), out_partial=0, out_valid one cycle after beat1.
- Averaging, mode=1 (DECIMATE_AVG_EN defined):
  - Stimulus: A[2k]=0xFF, A[2k+1]=0x00 on both beats.
  - Response: every lane=0x80. Repeat with 0xFF/0xFF: every lane=0xFF, no overflow.
- Flush:
  - Stimulus: one beat A[i]=i with mode=0, then flush=1 with in_valid=0.
  - Response: next cycle out_valid=1, out_partial=1, lanes 0..7={0,2,...,14}, lanes 8..15=0.
- Backpressure:
  - Stimulus: complete a vector, hold out_ready=0 for 5 cycles with in_valid=1.
  - Response: in_ready=0, Result stable, no beats lost. Raise out_ready: output handshake and a new beat accepted in the same cycle, state HALF.
- Flush collision:
  - Stimulus: in HALF, assert flush and an accepted beat together.
  - Response: complete vector, out_partial=0.
- Async reset:
  - Stimulus: assert rst_n=0 mid-HALF, between clock edges.
  - Response: out_valid and out_partial drop to 0 immediately, Result=0. After release, the first beat goes to the lower half.

Source files
------------

// File: rtl/vector_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : vector_decimator
//  Purpose  : Halves each V-lane vector pairwise and packs two beats into one
//             output vector. Optional macro DECIMATE_AVG_EN enables averaging.
//  Revision : 1.0  initial release
// ============================================================================
module vector_decimator #(
    parameter int N = 8,
    parameter int V = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [V-1:0][N-1:0]  A,
    input  logic                 mode,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [V-1:0][N-1:0]  Result,
    output logic                 out_partial
);

    localparam int H = V / 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                r_state;
    logic [H-1:0][N-1:0]   w_red;
    logic                  w_accept;

    generate
        for (genvar k = 0; k < H; k++) begin : g_lane
`ifdef DECIMATE_AVG_EN
            // N+1 bit sum keeps the carry so the rounded average never wraps
            logic [N:0] w_sum;
            assign w_sum    = {1'b0, A[2*k]} + {1'b0, A[2*k+1]} + (N+1)'(1);
            assign w_red[k] = mode ? w_sum[N:1] : A[2*k];
`else
            assign w_red[k] = A[2*k];
`endif
        end
    endgenerate

`ifndef DECIMATE_AVG_EN
    logic w_unused_ok;
    assign w_unused_ok = mode ^ (^A);
`endif

    assign in_ready = (r_state != FULL) || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            Result      <= '0;
            out_valid   <= 1'b0;
            out_partial <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        Result[H-1:0] <= w_red;
                        r_state       <= HALF;
                    end
                end
                HALF: begin
                    // A beat arriving together with flush completes the vector
                    if (w_accept) begin
                        Result[V-1:H] <= w_red;
                        out_valid     <= 1'b1;
                        out_partial   <= 1'b0;
                        r_state       <= FULL;
                    end else if (flush) begin
                        Result[V-1:H] <= '0;
                        out_valid     <= 1'b1;
                        out_partial   <= 1'b1;
                        r_state       <= FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_partial <= 1'b0;
                        if (w_accept) begin
                            Result[H-1:0] <= w_red;
                            r_state       <= HALF;
                        end else begin
                            r_state       <= EMPTY;
                        end
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    out_valid   <= 1'b0;
                    out_partial <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_decimator
//  Purpose  : Directed self-checking bench for vector_decimator (N=8, V=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_vector_decimator;

    localparam int N = 8;
    localparam int V = 16;

    typedef logic [V-1:0][N-1:0] vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    vec_t A;
    logic mode;
    logic flush;
    logic out_valid;
    logic out_ready;
    vec_t Result;
    logic out_partial;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vector_decimator #(.N(N), .V(V)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .mode        (mode),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Result      (Result),
        .out_partial (out_partial)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t ramp(input int base);
        vec_t v;
        for (int i = 0; i < V; i++) v[i] = 8'(base + i);
        return v;
    endfunction

    function automatic vec_t pair(input logic [7:0] ev, input logic [7:0] od);
        vec_t v;
        for (int i = 0; i < V; i += 2) begin
            v[i]   = ev;
            v[i+1] = od;
        end
        return v;
    endfunction

    function automatic vec_t fill(input logic [7:0] x);
        vec_t v;
        for (int i = 0; i < V; i++) v[i] = x;
        return v;
    endfunction

    // Expected packing of two ramp beats under even-lane pick
    function automatic vec_t decim(input int lo, input int hi, input bit hi_zero);
        vec_t v;
        for (int k = 0; k < V/2; k++) begin
            v[k]       = 8'(lo + 2*k);
            v[k + V/2] = hi_zero ? 8'h00 : 8'(hi + 2*k);
        end
        return v;
    endfunction

`ifdef DECIMATE_AVG_EN
    localparam logic [7:0] AVG_FF_00 = 8'h80;
`else
    localparam logic [7:0] AVG_FF_00 = 8'hFF;
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        A         = '0;
        mode      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_valid",   out_valid,   1'b0);
        check("rst_partial", out_partial, 1'b0);
        check("rst_result",  Result,      '0);
        check("rst_inready", in_ready,    1'b1);
        rst_n = 1'b1;
        step();

        // Even-lane pick
        A = ramp(0); mode = 1'b0; in_valid = 1'b1;
        check("even_inready", in_ready, 1'b1);
        step();
        check("even_half_novalid", out_valid, 1'b0);
        A = ramp(16);
        step();
        in_valid = 1'b0;
        check("even_valid",   out_valid,   1'b1);
        check("even_partial", out_partial, 1'b0);
        check("even_result",  Result,      decim(0, 16, 1'b0));
        step();
        check("even_drained", out_valid, 1'b0);

        // Averaging (falls back to even pick when the feature is not built)
        A = pair(8'hFF, 8'h00); mode = 1'b1; in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("avg_ff00", Result, fill(AVG_FF_00));
        step();
        A = pair(8'hFF, 8'hFF); in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0; mode = 1'b0;
        check("avg_ffff", Result, fill(8'hFF));
        step();

        // Flush of a half vector
        A = ramp(0); in_valid = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid",   out_valid,   1'b1);
        check("flush_partial", out_partial, 1'b1);
        check("flush_result",  Result,      decim(0, 0, 1'b1));
        step();
        check("flush_drained", out_valid, 1'b0);

        // Backpressure
        out_ready = 1'b0;
        A = ramp(32); in_valid = 1'b1;
        step();
        A = ramp(48);
        step();
        A = ramp(64);
        check("bp_valid", out_valid, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("bp_inready_low", in_ready, 1'b0);
            check("bp_stable",      Result,   decim(32, 48, 1'b0));
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_inready_comb", in_ready, 1'b1);
        step();
        check("bp_handoff_half", out_valid, 1'b0);
        A = ramp(80);
        step();
        in_valid = 1'b0;
        check("bp_next_valid",  out_valid, 1'b1);
        check("bp_next_result", Result,    decim(64, 80, 1'b0));
        step();

        // Flush colliding with an accepted beat
        A = ramp(96); in_valid = 1'b1;
        step();
        A = ramp(112); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("coll_valid",   out_valid,   1'b1);
        check("coll_partial", out_partial, 1'b0);
        check("coll_result",  Result,      decim(96, 112, 1'b0));
        step();

        // Async reset while an output is pending
        out_ready = 1'b0;
        A = ramp(0); in_valid = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("pend_partial", out_partial, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid",   out_valid,   1'b0);
        check("arst_partial", out_partial, 1'b0);
        check("arst_result",  Result,      '0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // Async reset mid-HALF
        A = ramp(32); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("arst_half_result",  Result,   '0);
        check("arst_half_inready", in_ready, 1'b1);
        #1 rst_n = 1'b1;
        step();
        A = ramp(16); in_valid = 1'b1;
        step();
        A = ramp(48);
        step();
        in_valid = 1'b0;
        check("post_rst_valid",  out_valid, 1'b1);
        check("post_rst_result", Result,    decim(16, 48, 1'b0));
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
